// File: rtl/multi_timer.sv
// Multi-channel timer: shared prescaler tick driving independent
// one-shot / periodic counters with sticky per-channel interrupts.
module multi_timer #(
   parameter int WIDTH      = 32,
   parameter int CHANNELS   = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS-1:0]       ro_trig_start,
   input  logic [CHANNELS-1:0]       ro_trig_halt,
   input  logic [CHANNELS-1:0]       ro_mode,
   input  logic [CHANNELS*WIDTH-1:0] ro_termcount,
   input  logic [PRESCALE_W-1:0]     ro_prescale,
   input  logic [CHANNELS-1:0]       ro_int_en,
   input  logic [CHANNELS-1:0]       ro_int_clr,
   output logic [CHANNELS-1:0]       rf_status,
   output logic [CHANNELS*WIDTH-1:0] rf_currcount,
   output logic [CHANNELS-1:0]       rf_int,
   output logic                      irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [PRESCALE_W-1:0] pre_q;
   logic                  tick;

   // >= so a lowered divider wraps on the next edge instead of overflowing
   assign tick = (pre_q >= ro_prescale);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_q <= '0;
      end else if (tick) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_q + PRESCALE_W'(1);
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      state_t           st_q;
      state_t           st_d;
      logic [WIDTH-1:0] cnt_q;
      logic [WIDTH-1:0] cnt_d;
      logic [WIDTH-1:0] tc;
      logic [WIDTH:0]   inc;
      logic             hit;
      logic             int_q;
      logic             int_d;

      assign tc  = ro_termcount[n*WIDTH +: WIDTH];
      assign inc = {1'b0, cnt_q} + (WIDTH+1)'(1);
      assign hit = (inc >= {1'b0, tc});

      always_comb begin
         st_d  = st_q;
         cnt_d = cnt_q;
         int_d = int_q;
         if (ro_int_clr[n]) begin
            int_d = 1'b0;
         end
         // halt beats start and terminal; start beats terminal (restart)
         if (ro_trig_halt[n]) begin
            st_d = IDLE;
         end else if (ro_trig_start[n] && (tc != '0)) begin
            st_d  = RUN;
            cnt_d = '0;
         end else if ((st_q == RUN) && tick) begin
            if (hit) begin
               int_d = 1'b1;
               if (ro_mode[n]) begin
                  cnt_d = '0;
               end else begin
                  cnt_d = tc;
                  st_d  = DONE;
               end
            end else begin
               cnt_d = inc[WIDTH-1:0];
            end
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            st_q  <= IDLE;
            cnt_q <= '0;
            int_q <= 1'b0;
         end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            int_q <= int_d;
         end
      end

      assign rf_status[n]                 = (st_q == RUN);
      assign rf_currcount[n*WIDTH +: WIDTH] = cnt_q;
      assign rf_int[n]                    = int_q;
   end

   assign irq = |(rf_int & ro_int_en);

endmodule
